// File: rtl/fpu_issue.sv
// Single-outstanding FP issue stage: latches a decode request, pulses it into the FPU,
// holds operator/operands until the result returns, then emits a one-cycle writeback.
module fpu_issue #(
    parameter int TIMEOUT = 63,
    parameter int RD_W    = 5
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [RD_W-1:0] req_rd,
    input  logic [31:0]     req_a,
    input  logic [31:0]     req_b,
    output logic            fpu_in_valid,
    output logic [2:0]      fpu_operator,
    output logic [31:0]     fpu_a,
    output logic [31:0]     fpu_b,
    input  logic            fpu_result_valid,
    input  logic [31:0]     fpu_c,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_rd,
    output logic [31:0]     wb_data,
    output logic            busy,
    output logic            err_illegal,
    output logic            err_timeout
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_WB    = 2'd3;
    localparam logic [2:0] OP_MAX  = 3'd4;
    localparam logic [7:0] CNT_END = 8'(TIMEOUT - 1);

    logic [1:0]      state;
    logic [7:0]      cnt;
    logic [RD_W-1:0] rd_q;

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    // The FPU picks its result by fpu_operator, so operator/operands are only
    // written on an accepted legal request and otherwise held.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= S_IDLE;
            cnt          <= '0;
            rd_q         <= '0;
            fpu_in_valid <= 1'b0;
            fpu_operator <= '0;
            fpu_a        <= '0;
            fpu_b        <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            err_illegal  <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            fpu_in_valid <= 1'b0;
            wb_valid     <= 1'b0;
            err_illegal  <= 1'b0;
            err_timeout  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (req_op <= OP_MAX) begin
                            fpu_operator <= req_op;
                            fpu_a        <= req_a;
                            fpu_b        <= req_b;
                            rd_q         <= req_rd;
                            fpu_in_valid <= 1'b1;
                            state        <= S_ISSUE;
                        end else begin
                            err_illegal <= 1'b1;
                        end
                    end
                end
                // A result strobe seen here belongs to nothing we issued.
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (fpu_result_valid) begin
                        wb_valid <= 1'b1;
                        wb_data  <= fpu_c;
                        wb_rd    <= rd_q;
                        state    <= S_WB;
                    end else if (cnt == CNT_END) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_WB:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
